// File: rtl/i2c_pkg.sv
// rtl/i2c_pkg.sv - shared FSM state encoding, bus constants and default address for the I2C target
package i2c_pkg;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_ADDR,
        ST_ADDR_ACK,
        ST_PTR,
        ST_PTR_ACK,
        ST_WDATA,
        ST_WDATA_ACK,
        ST_RDATA,
        ST_RDATA_ACK
    } i2c_state_e;

    localparam logic       I2C_ACK          = 1'b0;
    localparam logic       I2C_NACK         = 1'b1;
    localparam logic [6:0] I2C_DEFAULT_ADDR = 7'h42;

endpackage

// File: rtl/i2c_line_sync.sv
// rtl/i2c_line_sync.sv - 2-flop synchronizer, optional majority filter (I2C_TARGET_GLITCH_FILTER_EN), edge detect
module i2c_line_sync (
    input  logic clk,
    input  logic reset,
    input  logic line_i,
    output logic level_o,
    output logic rise_o,
    output logic fall_o
);

    logic [1:0] sync_q;
    logic       level;
    logic       prev_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync_q <= 2'b11;
        end else begin
            sync_q <= {sync_q[0], line_i};
        end
    end

`ifdef I2C_TARGET_GLITCH_FILTER_EN
    // A one-clk pulse never holds two of the three samples, so it cannot flip the output.
    logic [1:0] hist_q;
    logic       filt_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hist_q <= 2'b11;
            filt_q <= 1'b1;
        end else begin
            hist_q <= {hist_q[0], sync_q[1]};
            filt_q <= (sync_q[1] & hist_q[0]) | (sync_q[1] & hist_q[1]) | (hist_q[0] & hist_q[1]);
        end
    end

    assign level = filt_q;
`else
    assign level = sync_q[1];
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            prev_q <= 1'b1;
        end else begin
            prev_q <= level;
        end
    end

    assign level_o = level;
    assign rise_o  = level & ~prev_q;
    assign fall_o  = ~level & prev_q;

endmodule

// File: rtl/i2c_target.sv
// rtl/i2c_target.sv - I2C register-file target; I2C_TARGET_GLITCH_FILTER_EN adds line majority filters
module i2c_target
    import i2c_pkg::*;
#(
    parameter logic [6:0] TARGET_ADDR = I2C_DEFAULT_ADDR,
    parameter int         NUM_REGS    = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       scl_i,
    input  logic       sda_i,
    output logic       sda_oe,
    output logic       wr_valid,
    output logic [7:0] wr_addr,
    output logic [7:0] wr_data,
    output logic       busy
);

    localparam int PW = $clog2(NUM_REGS);

    logic scl_lvl, scl_rise, scl_fall;
    logic sda_lvl, sda_rise, sda_fall;

    i2c_line_sync u_scl_sync (
        .clk    (clk),
        .reset  (reset),
        .line_i (scl_i),
        .level_o(scl_lvl),
        .rise_o (scl_rise),
        .fall_o (scl_fall)
    );

    i2c_line_sync u_sda_sync (
        .clk    (clk),
        .reset  (reset),
        .line_i (sda_i),
        .level_o(sda_lvl),
        .rise_o (sda_rise),
        .fall_o (sda_fall)
    );

    i2c_state_e    state_q, state_d;
    logic [3:0]    cnt_q, cnt_d;
    logic [7:0]    shift_q, shift_d;
    logic [PW-1:0] ptr_q, ptr_d;
    logic          rw_q, rw_d;
    logic          oe_q, oe_d;
    logic          busy_q, busy_d;
    logic          wr_valid_q, wr_valid_d;
    logic [7:0]    wr_addr_q, wr_addr_d;
    logic [7:0]    wr_data_q, wr_data_d;
    logic [7:0]    regs_q [NUM_REGS];
    logic          reg_we;
    logic [7:0]    rx_byte;
    logic [7:0]    rd_byte;
    logic          start_det, stop_det;

    assign start_det = sda_fall & scl_lvl;
    assign stop_det  = sda_rise & scl_lvl;
    assign rx_byte   = {shift_q[6:0], sda_lvl};
    assign rd_byte   = regs_q[ptr_q];

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        shift_d    = shift_q;
        ptr_d      = ptr_q;
        rw_d       = rw_q;
        oe_d       = oe_q;
        busy_d     = busy_q;
        wr_valid_d = 1'b0;
        wr_addr_d  = wr_addr_q;
        wr_data_d  = wr_data_q;
        reg_we     = 1'b0;
        if (start_det) begin
            state_d = ST_ADDR;
            cnt_d   = 4'd0;
            oe_d    = 1'b0;
        end else if (stop_det) begin
            state_d = ST_IDLE;
            cnt_d   = 4'd0;
            oe_d    = 1'b0;
            busy_d  = 1'b0;
        end else if (scl_rise) begin
            case (state_q)
                ST_ADDR, ST_PTR, ST_WDATA: begin
                    shift_d = rx_byte;
                    cnt_d   = cnt_q + 4'd1;
                    if (state_q == ST_WDATA && cnt_q == 4'd7) begin
                        reg_we     = 1'b1;
                        wr_valid_d = 1'b1;
                        wr_addr_d  = 8'(ptr_q);
                        wr_data_d  = rx_byte;
                        ptr_d      = ptr_q + PW'(1);
                    end
                end
                ST_RDATA: cnt_d = cnt_q + 4'd1;
                ST_RDATA_ACK: begin
                    if (sda_lvl == I2C_NACK) begin
                        state_d = ST_IDLE;
                        busy_d  = 1'b0;
                    end else begin
                        ptr_d = ptr_q + PW'(1);
                    end
                end
                default: ;
            endcase
        end else if (scl_fall) begin
            // Every SDA change happens here, while SCL is low.
            case (state_q)
                ST_ADDR: begin
                    if (cnt_q == 4'd8) begin
                        cnt_d = 4'd0;
                        if (shift_q[7:1] == TARGET_ADDR) begin
                            state_d = ST_ADDR_ACK;
                            oe_d    = 1'b1;
                            busy_d  = 1'b1;
                            rw_d    = shift_q[0];
                        end else begin
                            state_d = ST_IDLE;
                            busy_d  = 1'b0;
                        end
                    end
                end
                ST_ADDR_ACK, ST_RDATA_ACK: begin
                    cnt_d = 4'd0;
                    if (state_q == ST_RDATA_ACK || rw_q) begin
                        state_d = ST_RDATA;
                        shift_d = rd_byte;
                        oe_d    = ~rd_byte[7];
                    end else begin
                        state_d = ST_PTR;
                        oe_d    = 1'b0;
                    end
                end
                ST_PTR: begin
                    if (cnt_q == 4'd8) begin
                        ptr_d   = shift_q[PW-1:0];
                        state_d = ST_PTR_ACK;
                        oe_d    = 1'b1;
                        cnt_d   = 4'd0;
                    end
                end
                ST_PTR_ACK, ST_WDATA_ACK: begin
                    state_d = ST_WDATA;
                    oe_d    = 1'b0;
                end
                ST_WDATA: begin
                    if (cnt_q == 4'd8) begin
                        state_d = ST_WDATA_ACK;
                        oe_d    = 1'b1;
                        cnt_d   = 4'd0;
                    end
                end
                ST_RDATA: begin
                    if (cnt_q == 4'd8) begin
                        state_d = ST_RDATA_ACK;
                        oe_d    = 1'b0;
                        cnt_d   = 4'd0;
                    end else begin
                        shift_d = {shift_q[6:0], 1'b0};
                        oe_d    = ~shift_q[6];
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_IDLE;
            cnt_q      <= 4'd0;
            shift_q    <= 8'h00;
            ptr_q      <= '0;
            rw_q       <= 1'b0;
            oe_q       <= 1'b0;
            busy_q     <= 1'b0;
            wr_valid_q <= 1'b0;
            wr_addr_q  <= 8'h00;
            wr_data_q  <= 8'h00;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            shift_q    <= shift_d;
            ptr_q      <= ptr_d;
            rw_q       <= rw_d;
            oe_q       <= oe_d;
            busy_q     <= busy_d;
            wr_valid_q <= wr_valid_d;
            wr_addr_q  <= wr_addr_d;
            wr_data_q  <= wr_data_d;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= 8'h00;
            end
        end else if (reg_we) begin
            regs_q[ptr_q] <= wr_data_d;
        end
    end

    assign sda_oe   = oe_q;
    assign wr_valid = wr_valid_q;
    assign wr_addr  = wr_addr_q;
    assign wr_data  = wr_data_q;
    assign busy     = busy_q;

endmodule

// File: tb/tb_i2c_target.sv
// tb/tb_i2c_target.sv - randomized self-checking bench for i2c_target against a register-file model
module tb_i2c_target;

    localparam int NR  = 16;
    localparam int QTR = 8;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       scl = 1'b1;
    logic       sda_drv = 1'b1;
    logic       sda_oe;
    logic       wr_valid;
    logic [7:0] wr_addr;
    logic [7:0] wr_data;
    logic       busy;
    wire        sda_bus;

    assign sda_bus = sda_drv & ~sda_oe;

    i2c_target #(.TARGET_ADDR(7'h42), .NUM_REGS(NR)) dut (
        .clk     (clk),
        .reset   (reset),
        .scl_i   (scl),
        .sda_i   (sda_bus),
        .sda_oe  (sda_oe),
        .wr_valid(wr_valid),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .busy    (busy)
    );

    always #5 clk = ~clk;

    int          n_cmp = 0;
    int          n_err = 0;
    logic [7:0]  mdl_regs [NR];
    int          mdl_ptr;
    logic [7:0]  wbuf [4];
    logic [15:0] obs_q [$];
    logic [15:0] exp_q [$];
    int          obs_rd = 0;
    int          oe_cnt = 0;

    always @(negedge clk) begin
        if (wr_valid) obs_q.push_back({wr_addr, wr_data});
        if (sda_oe) oe_cnt++;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic q_wait();
        repeat (QTR) @(negedge clk);
    endtask

    task automatic bus_start();
        sda_drv = 1'b1; q_wait();
        scl = 1'b1;     q_wait();
        sda_drv = 1'b0; q_wait();
        scl = 1'b0;     q_wait();
    endtask

    task automatic bus_stop();
        sda_drv = 1'b0; q_wait();
        scl = 1'b1;     q_wait();
        sda_drv = 1'b1; q_wait();
    endtask

    task automatic send_bit(input logic b);
        sda_drv = b; q_wait();
        scl = 1'b1;  q_wait(); q_wait();
        scl = 1'b0;  q_wait();
    endtask

    task automatic tx_byte(input logic [7:0] b, output logic acked);
        for (int i = 7; i >= 0; i--) send_bit(b[i]);
        sda_drv = 1'b1; q_wait();
        scl = 1'b1;     q_wait();
        acked = ~sda_bus;
        q_wait();
        scl = 1'b0;     q_wait();
    endtask

    task automatic rx_byte(input logic nack, output logic [7:0] b);
        b = 8'h00;
        for (int i = 0; i < 8; i++) begin
            sda_drv = 1'b1; q_wait();
            scl = 1'b1;     q_wait();
            b = {b[6:0], sda_bus};
            q_wait();
            scl = 1'b0;     q_wait();
        end
        send_bit(nack);
    endtask

    task automatic compare_writes(input string tag);
        int n;
        n = obs_q.size() - obs_rd;
        check_eq({tag, "_count"}, n, exp_q.size());
        for (int i = 0; i < n && i < exp_q.size(); i++)
            check_eq(tag, obs_q[obs_rd + i], exp_q[i]);
        obs_rd = obs_q.size();
        exp_q.delete();
    endtask

    task automatic do_write(input logic [7:0] p, input int n);
        logic ack;
        bus_start();
        tx_byte(8'h84, ack);   check_eq("w_addr_ack", ack, 1);
        check_eq("w_busy", busy, 1);
        tx_byte(p, ack);       check_eq("w_ptr_ack", ack, 1);
        mdl_ptr = p % NR;
        for (int i = 0; i < n; i++) begin
            tx_byte(wbuf[i], ack);
            check_eq("w_data_ack", ack, 1);
            exp_q.push_back({8'(mdl_ptr), wbuf[i]});
            mdl_regs[mdl_ptr] = wbuf[i];
            mdl_ptr = (mdl_ptr + 1) % NR;
        end
        bus_stop(); q_wait();
        check_eq("w_busy_stop", busy, 0);
        compare_writes("w_entry");
    endtask

    task automatic do_read(input logic [7:0] p, input int n, input bit set_ptr);
        logic       ack;
        logic [7:0] got;
        if (set_ptr) begin
            bus_start();
            tx_byte(8'h84, ack); check_eq("r_waddr_ack", ack, 1);
            tx_byte(p, ack);     check_eq("r_ptr_ack", ack, 1);
            mdl_ptr = p % NR;
        end
        bus_start();
        tx_byte(8'h85, ack);     check_eq("r_addr_ack", ack, 1);
        for (int i = 0; i < n; i++) begin
            rx_byte(i == n - 1, got);
            check_eq("r_data", got, mdl_regs[mdl_ptr]);
            if (i != n - 1) mdl_ptr = (mdl_ptr + 1) % NR;
        end
        check_eq("r_busy_nack", busy, 0);
        check_eq("r_oe_nack", sda_oe, 0);
        bus_stop(); q_wait();
        compare_writes("r_no_write");
    endtask

    initial begin
        logic       ack;
        int         base;
        int         n;
        logic [7:0] p;

        for (int i = 0; i < NR; i++) mdl_regs[i] = 8'h00;
        mdl_ptr = 0;

        repeat (5) @(negedge clk);
        check_eq("rst_sda_oe", sda_oe, 0);
        check_eq("rst_wr_valid", wr_valid, 0);
        check_eq("rst_wr_addr", wr_addr, 0);
        check_eq("rst_wr_data", wr_data, 0);
        check_eq("rst_busy", busy, 0);
        reset = 1'b1;
        q_wait();

        wbuf[0] = 8'hA5;
        do_write(8'h03, 1);
        do_read(8'h03, 2, 1);

        bus_start();
        base = oe_cnt;
        tx_byte(8'h86, ack);
        check_eq("miss_ack", ack, 0);
        check_eq("miss_busy", busy, 0);
        check_eq("miss_oe_cycles", oe_cnt - base, 0);
        bus_stop(); q_wait();
        compare_writes("miss_write");

        wbuf[0] = 8'h11; wbuf[1] = 8'h22;
        do_write(8'h0F, 2);
        do_read(8'h00, 1, 1);

        for (int t = 0; t < 6; t++) begin
            p = 8'($urandom_range(0, 255));
            n = $urandom_range(1, 4);
            for (int i = 0; i < 4; i++) wbuf[i] = 8'($urandom_range(0, 255));
            do_write(p, n);
            do_read(8'($urandom_range(0, 255)), $urandom_range(1, 4), 1);
            do_read(8'h00, $urandom_range(1, 3), 0);
        end

        bus_start();
        tx_byte(8'h84, ack); check_eq("abort_addr_ack", ack, 1);
        tx_byte(8'h05, ack); check_eq("abort_ptr_ack", ack, 1);
        mdl_ptr = 5;
        for (int i = 0; i < 4; i++) send_bit(1'($urandom_range(0, 1)));
        bus_stop(); q_wait();
        check_eq("abort_oe", sda_oe, 0);
        check_eq("abort_busy", busy, 0);
        compare_writes("abort_write");
        do_read(8'h00, 1, 0);

`ifdef I2C_TARGET_GLITCH_FILTER_EN
        @(negedge clk) sda_drv = 1'b0;
        @(negedge clk) sda_drv = 1'b1;
        q_wait();
        scl = 1'b0; q_wait();
        tx_byte(8'h84, ack);
        check_eq("glitch_ack", ack, 0);
        check_eq("glitch_busy", busy, 0);
        bus_stop(); q_wait();
`endif

        wbuf[0] = 8'h3C;
        do_write(8'h0A, 1);
        bus_start();
        tx_byte(8'h84, ack); check_eq("mr_waddr_ack", ack, 1);
        tx_byte(8'h0A, ack); check_eq("mr_ptr_ack", ack, 1);
        bus_start();
        tx_byte(8'h85, ack); check_eq("mr_addr_ack", ack, 1);
        check_eq("mr_oe_drive", sda_oe, 1);
        reset = 1'b0;
        #1;
        check_eq("mr_oe_async", sda_oe, 0);
        check_eq("mr_busy", busy, 0);
        scl = 1'b1; sda_drv = 1'b1;
        repeat (4) @(negedge clk);
        check_eq("mr_wr_addr", wr_addr, 0);
        reset = 1'b1;
        for (int i = 0; i < NR; i++) mdl_regs[i] = 8'h00;
        mdl_ptr = 0;
        q_wait();
        do_read(8'h00, 2, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/i2c_target.md
I2C_TARGET -- requirements
Module: i2c_target

Interface
REQ-001 Parameter: TARGET_ADDR, 7'h42, 7-bit I2C address the block responds to.
REQ-002 Parameter: NUM_REGS, 16, number of 8-bit internal registers; power of two, 2..256.
REQ-003 Port: clk  input  1  system clock, at least 16x SCL frequency.
REQ-004 Port: reset  input  1  asynchronous, active-low reset.
REQ-005 Port: scl_i  input  1  SCL line level, asynchronous to clk.
REQ-006 Port: sda_i  input  1  SDA line level, asynchronous to clk.
REQ-007 Port: sda_oe  output  1  1 = pull SDA low (open-drain); 0 = release.
REQ-008 Port: wr_valid  output  1  one-clk pulse per data byte written by the controller.
REQ-009 Port: wr_addr  output  8  register index of that write; valid with wr_valid.
REQ-010 Port: wr_data  output  8  written byte; valid with wr_valid.
REQ-011 Port: busy  output  1  high from an addressed START until STOP or NACK-idle.

Function
REQ-012 SCL and SDA SHALL each pass through a 2-flop synchronizer; edges are detected on synchronized values (2-3 clk detection latency).
REQ-013 START = SDA fall while SCL high; STOP = SDA rise while SCL high; both SHALL be recognized in every state, and a repeated START SHALL return the FSM to ADDR.
REQ-014 FSM states: IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WDATA, WDATA_ACK, RDATA, RDATA_ACK.
REQ-015 Bits are sampled on SCL rise, MSB first; sda_oe changes only after an SCL fall.
REQ-016 ADDR: after 8 bits, on address match go to ADDR_ACK and drive ACK (sda_oe=1) for one SCL period; on mismatch return to IDLE with sda_oe=0 until the next START.
REQ-017 R/W=0: the next byte is the register pointer (PTR, then ACK); subsequent bytes go to WDATA, ACK each, write regs[ptr], pulse wr_valid one clk after the 8th bit, then ptr increments.
REQ-018 R/W=1: RDATA shifts out regs[ptr] MSB first (sda_oe = ~bit); RDATA_ACK samples the controller ACK: ACK -> ptr+1 and next byte; NACK -> IDLE.
REQ-019 Pointer arithmetic SHALL wrap modulo NUM_REGS; pointer bytes >= NUM_REGS SHALL be masked to log2(NUM_REGS) bits and still ACKed.
REQ-020 A STOP mid-byte SHALL discard the partial byte (no wr_valid) and release SDA within 1 clk of detection.
REQ-021 Pointer and register contents persist across transactions; only reset clears them.
REQ-022 Clock stretching and 10-bit addressing SHALL NOT be supported.

Reset
REQ-023 On reset low: FSM=IDLE, sda_oe=0, wr_valid=0, wr_addr=0, wr_data=0, busy=0, ptr=0, all registers 8'h00, synchronizer flops 1 (bus-idle level).
REQ-024 Reset asserted mid-transaction SHALL release SDA immediately (asynchronously); after release, the block waits for a fresh START.

Configuration
REQ-025 Macro I2C_TARGET_GLITCH_FILTER_EN: when defined, each synchronized line passes a 3-sample majority filter (+2 clk latency) that rejects pulses shorter than 2 clk; when undefined, no filter is present and latency is as in REQ-012.

Structure
REQ-026 Package i2c_pkg SHALL hold the FSM state enum, ACK/NACK constants and the default target address.
REQ-027 Sub-module i2c_line_sync (synchronizer, optional filter, rise/fall detect) SHALL be instantiated once per line.

Verification
REQ-028 Write: START, 0x84, ptr 0x03, data 0xA5, STOP -> three ACKs; wr_valid once with wr_addr=3, wr_data=0xA5.
REQ-029 Read: write ptr 0x03, repeated START, 0x85, read 2 bytes (ACK, NACK) -> 0xA5 then regs[4]=0x00; FSM IDLE after NACK.
REQ-030 Address mismatch: START, 0x86 -> no ACK, sda_oe stays 0, busy=0, no wr_valid.
REQ-031 Wrap: ptr 0x0F, write 0x11, 0x22 -> wr_addr 15 then 0; readback of regs[0] = 0x22.
REQ-032 Abort: STOP after 4 data bits -> no wr_valid, sda_oe=0; reset low mid-read -> sda_oe=0 in the same cycle.
REQ-033 With I2C_TARGET_GLITCH_FILTER_EN: 1-clk SDA low glitch while SCL high -> no START detected.
